// File: rtl/adder_tree_acc.sv
// adder_tree_acc: registered-input signed adder tree feeding a saturating multi-beat group accumulator
module adder_tree_acc #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   vld_i,
  input  logic                   last_i,
  input  logic [N_IN*IN_W-1:0]   mul_i,
  output logic [ACC_W-1:0]       sum_o,
  output logic                   vld_o,
  output logic                   ovf_o
);
  localparam int LVL = $clog2(N_IN);
  localparam int TW  = IN_W + LVL;
  genvar j, k;
  // level 0 is the input register; level j holds ceil(N_IN/2^j) nodes of IN_W+j bits
  for (j = 0; j <= LVL; j++) begin : g_lvl
    localparam int NJ = (N_IN + (1 << j) - 1) >> j;
    for (k = 0; k < NJ; k++) begin : g_node
      logic signed [IN_W+j-1:0] r_node;
      if (j == 0) begin : g_in
        always_ff @(posedge clk) r_node <= !rstn ? '0 : mul_i[k*IN_W +: IN_W];
      end else begin : g_add
        localparam int NP = (N_IN + (1 << (j - 1)) - 1) >> (j - 1);
        logic [IN_W+j-1:0] w_a, w_b;
        assign w_a = {g_lvl[j-1].g_node[2*k].r_node[IN_W+j-2], g_lvl[j-1].g_node[2*k].r_node};
        if (2*k+1 < NP) begin : g_pair
          assign w_b = {g_lvl[j-1].g_node[2*k+1].r_node[IN_W+j-2], g_lvl[j-1].g_node[2*k+1].r_node};
        end else begin : g_pass
          assign w_b = '0;
        end
        always_ff @(posedge clk) r_node <= !rstn ? '0 : w_a + w_b;
      end
    end
  end
  logic [TW-1:0] w_tree;
  assign w_tree = g_lvl[LVL].g_node[0].r_node;
  logic [LVL:0] r_vld, r_last;
  always_ff @(posedge clk) begin
    r_vld  <= !rstn ? '0 : {r_vld[LVL-1:0], vld_i};
    r_last <= !rstn ? '0 : {r_last[LVL-1:0], vld_i & last_i};
  end
  logic             w_tv, w_tl, w_sat;
  logic [ACC_W:0]   w_base, w_s;
  logic [ACC_W-1:0] w_clamp, r_acc;
  logic             r_ovf, r_first, r_vo;
  assign w_tv = r_vld[LVL];
  assign w_tl = r_last[LVL];
  // one extra bit is enough: a single tree sum never exceeds the accumulator range
  always_comb begin
    w_base  = r_first ? '0 : {r_acc[ACC_W-1], r_acc};
    w_s     = w_base + {{(ACC_W+1-TW){w_tree[TW-1]}}, w_tree};
    w_sat   = w_s[ACC_W] ^ w_s[ACC_W-1];
    w_clamp = !w_sat ? w_s[ACC_W-1:0] : w_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_first <= 1'b1;
      r_vo    <= 1'b0;
    end else begin
      r_vo <= w_tv & w_tl;
      if (w_tv) begin
        r_acc   <= w_clamp;
        r_ovf   <= (!r_first & r_ovf) | w_sat;
        r_first <= w_tl;
      end
    end
  end
  assign sum_o = r_acc;
  assign ovf_o = r_ovf;
  assign vld_o = r_vo;
endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed checks of a 32-bit and a 20-bit accumulator build sharing one stimulus
module tb_adder_tree_acc;
  localparam int N = 9;
  localparam int W = 16;
  logic clk = 1'b0, rstn = 1'b0, vld_i = 1'b0, last_i = 1'b0;
  logic [N*W-1:0] mul_i = '0;
  logic [31:0] a_sum;
  logic [19:0] s_sum;
  logic a_vld, a_ovf, s_vld, s_ovf;
  int checks = 0, errors = 0;
  logic signed [31:0] qa[$], qs[$];
  logic qa_o[$], qs_o[$];
  always #5 clk = ~clk;
  adder_tree_acc #(.N_IN(N), .IN_W(W), .ACC_W(32)) u_a (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .last_i(last_i), .mul_i(mul_i),
    .sum_o(a_sum), .vld_o(a_vld), .ovf_o(a_ovf));
  adder_tree_acc #(.N_IN(N), .IN_W(W), .ACC_W(20)) u_s (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .last_i(last_i), .mul_i(mul_i),
    .sum_o(s_sum), .vld_o(s_vld), .ovf_o(s_ovf));
  always @(posedge clk) begin
    #1;
    if (a_vld) begin
      qa.push_back(a_sum);
      qa_o.push_back(a_ovf);
    end
    if (s_vld) begin
      qs.push_back({{12{s_sum[19]}}, s_sum});
      qs_o.push_back(s_ovf);
    end
  end
  function automatic logic [N*W-1:0] mk(input int a, input int b, input int nb);
    logic [N*W-1:0] m;
    m = '0;
    m[W-1:0] = 16'(a);
    for (int i = 1; i <= nb; i++) m[i*W +: W] = 16'(b);
    return m;
  endfunction
  task automatic beat(input logic [N*W-1:0] m, input logic l);
    vld_i = 1'b1;
    last_i = l;
    mul_i = m;
    @(negedge clk);
    vld_i = 1'b0;
    last_i = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) mul_i[i*W +: W] = 16'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic flush();
    qa.delete(); qa_o.delete(); qs.delete(); qs_o.delete();
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    vld_i = 1'b1;
    last_i = 1'b1;
    mul_i = mk(1, 1, 8);
    idle(3);
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", a_vld); end
    checks++; if (a_sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %0d want 0", a_sum); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", a_ovf); end
    checks++; if (s_vld !== 1'b0 || s_sum !== 20'd0 || s_ovf !== 1'b0) begin errors++; $display("FAIL reset_s got vld=%b sum=%0d ovf=%b want 0/0/0", s_vld, s_sum, s_ovf); end
    vld_i = 1'b0;
    last_i = 1'b0;
    rstn = 1'b1;
    idle(2);
  endtask
  task automatic test_single();
    beat(mk(1, 1, 8), 1'b1);
    for (int i = 1; i <= 5; i++) begin
      checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_early%0d got vld=%b want 0", i, a_vld); end
      @(negedge clk);
    end
    checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %b want 1", a_vld); end
    checks++; if ($signed(a_sum) !== 32'sd9) begin errors++; $display("FAIL single_sum got %0d want 9", $signed(a_sum)); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got %b want 0", a_ovf); end
    @(negedge clk);
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_pulse got vld=%b want 0", a_vld); end
    checks++; if ($signed(a_sum) !== 32'sd9) begin errors++; $display("FAIL single_hold got %0d want 9", $signed(a_sum)); end
  endtask
  task automatic test_extremes();
    flush();
    beat(mk(-32768, -32768, 8), 1'b1);
    beat(mk(32767, 32767, 8), 1'b1);
    idle(8);
    checks++; if (qa.size() !== 2) begin errors++; $display("FAIL ext_count got %0d want 2", qa.size()); end
    checks++; if ((qa.size() > 0 ? qa[0] : 32'sd0) !== -32'sd294912) begin errors++; $display("FAIL ext_neg got %0d want -294912", qa.size() > 0 ? qa[0] : 32'sd0); end
    checks++; if ((qa.size() > 1 ? qa[1] : 32'sd0) !== 32'sd294903) begin errors++; $display("FAIL ext_pos got %0d want 294903", qa.size() > 1 ? qa[1] : 32'sd0); end
    checks++; if ((qa_o.size() > 1 ? qa_o[0] | qa_o[1] : 1'b1) !== 1'b0) begin errors++; $display("FAIL ext_ovf got 1 want 0"); end
  endtask
  task automatic test_bubbles();
    flush();
    beat(mk(2, 1, 8), 1'b0);
    idle(2);
    beat(mk(4, -1, 8), 1'b0);
    idle(2);
    beat(mk(4, 12, 8), 1'b1);
    idle(8);
    checks++; if (qa.size() !== 1) begin errors++; $display("FAIL bub_count got %0d want 1", qa.size()); end
    checks++; if ((qa.size() > 0 ? qa[0] : 32'sd0) !== 32'sd106) begin errors++; $display("FAIL bub_sum got %0d want 106", qa.size() > 0 ? qa[0] : 32'sd0); end
    checks++; if ((qa_o.size() > 0 ? qa_o[0] : 1'b1) !== 1'b0) begin errors++; $display("FAIL bub_ovf got 1 want 0"); end
  endtask
  task automatic test_back_to_back();
    flush();
    beat(mk(5, 0, 0), 1'b1);
    beat(mk(7, 0, 0), 1'b0);
    beat(mk(0, 1, 8), 1'b1);
    idle(8);
    checks++; if (qa.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", qa.size()); end
    checks++; if ((qa.size() > 0 ? qa[0] : 32'sd0) !== 32'sd5) begin errors++; $display("FAIL b2b_first got %0d want 5", qa.size() > 0 ? qa[0] : 32'sd0); end
    checks++; if ((qa.size() > 1 ? qa[1] : 32'sd0) !== 32'sd15) begin errors++; $display("FAIL b2b_second got %0d want 15", qa.size() > 1 ? qa[1] : 32'sd0); end
  endtask
  task automatic test_saturation();
    flush();
    repeat (2) beat(mk(32767, 32767, 8), 1'b0);
    beat(mk(32767, 32767, 8), 1'b1);
    beat(mk(1, 1, 8), 1'b1);
    repeat (2) beat(mk(-32768, -32768, 8), 1'b0);
    beat(mk(-32768, -32768, 8), 1'b1);
    beat(mk(1, 1, 8), 1'b1);
    idle(8);
    checks++; if (qs.size() !== 4) begin errors++; $display("FAIL sat_count got %0d want 4", qs.size()); end
    checks++; if ((qs.size() > 0 ? qs[0] : 32'sd0) !== 32'sd524287) begin errors++; $display("FAIL sat_pos got %0d want 524287", qs.size() > 0 ? qs[0] : 32'sd0); end
    checks++; if ((qs_o.size() > 0 ? qs_o[0] : 1'b0) !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf got 0 want 1"); end
    checks++; if ((qs.size() > 1 ? qs[1] : 32'sd0) !== 32'sd9) begin errors++; $display("FAIL sat_fresh got %0d want 9", qs.size() > 1 ? qs[1] : 32'sd0); end
    checks++; if ((qs_o.size() > 1 ? qs_o[1] : 1'b1) !== 1'b0) begin errors++; $display("FAIL sat_fresh_ovf got 1 want 0"); end
    checks++; if ((qs.size() > 2 ? qs[2] : 32'sd0) !== -32'sd524288) begin errors++; $display("FAIL sat_neg got %0d want -524288", qs.size() > 2 ? qs[2] : 32'sd0); end
    checks++; if ((qs_o.size() > 2 ? qs_o[2] : 1'b0) !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf got 0 want 1"); end
    checks++; if ((qs_o.size() > 3 ? qs_o[3] : 1'b1) !== 1'b0) begin errors++; $display("FAIL sat_neg_fresh_ovf got 1 want 0"); end
    checks++; if ((qa.size() > 0 ? qa[0] : 32'sd0) !== 32'sd884709) begin errors++; $display("FAIL wide_nosat got %0d want 884709", qa.size() > 0 ? qa[0] : 32'sd0); end
    checks++; if ((qa_o.size() > 0 ? qa_o[0] : 1'b1) !== 1'b0) begin errors++; $display("FAIL wide_ovf got 1 want 0"); end
  endtask
  task automatic test_reset_mid();
    flush();
    beat(mk(100, 100, 8), 1'b0);
    beat(mk(200, 200, 8), 1'b0);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    beat(mk(1, 1, 2), 1'b1);
    idle(8);
    checks++; if (qa.size() !== 1) begin errors++; $display("FAIL rmid_count got %0d want 1", qa.size()); end
    checks++; if ((qa.size() > 0 ? qa[0] : 32'sd0) !== 32'sd3) begin errors++; $display("FAIL rmid_sum got %0d want 3", qa.size() > 0 ? qa[0] : 32'sd0); end
    flush();
    beat(mk(50, 0, 0), 1'b1);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    idle(8);
    checks++; if (qa.size() !== 0) begin errors++; $display("FAIL rmid_lost got %0d pulses want 0", qa.size()); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_extremes();
    test_bubbles();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
